// File: rtl/ddr3_wr_ctrl.sv
// Write side of the DDR3 frame buffer: packs a pixel stream into MIG-width words,
// buffers them and issues single-beat MIG write commands across a wrapping address window.
module ddr3_wr_ctrl #(
  parameter int DATA_IN_WIDTH = 16,
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 28,
  parameter int ADDR_INC      = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                      wr_clk,
  input  logic                      rst_n,
  input  logic                      init_calib_complete,
  input  logic                      wr_req,
  input  logic [ADDR_WIDTH-1:0]     wr_address_beign,
  input  logic [ADDR_WIDTH-1:0]     wr_address_end,
  input  logic [DATA_IN_WIDTH-1:0]  wr_din,
  input  logic                      wr_din_vld,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [DATA_WIDTH-1:0]     app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                      app_wdf_rdy,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overflow
);

  localparam int RATIO = DATA_WIDTH / DATA_IN_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]         LAST_BEAT = CW'(RATIO - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_INC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t state, state_nxt;

  logic                  req;
  logic [ADDR_WIDTH-1:0] win_begin, win_end, cur_addr, next_addr;
  logic                  wrap;
  logic                  cmd_done, data_done, discard;
  logic                  cmd_acc, data_acc, complete, retire, load;

  logic [CW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] pack_buf, pack_next, push_data;
  logic                  push_vld, pix_take, mem_we;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full;

  assign req        = wr_req & init_calib_complete;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign cmd_acc   = (state == S_WRITE) & ~cmd_done & app_rdy;
  assign data_acc  = (state == S_WRITE) & ~data_done & app_wdf_rdy;
  assign complete  = init_calib_complete & (state == S_WRITE) &
                     (cmd_done | cmd_acc) & (data_done | data_acc);
  // A word in flight when a new session starts finishes on the bus but is not counted.
  assign retire    = complete & ~discard & ~wr_req;
  assign next_addr = cur_addr + ADDR_STEP;
  assign wrap      = (next_addr >= win_end);
  assign load      = (state == S_WAIT) && (state_nxt == S_WRITE);

  assign pix_take  = (state != S_IDLE) & init_calib_complete & ~wr_req & wr_din_vld;
  assign mem_we    = init_calib_complete & ~wr_req & push_vld & ~fifo_full;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!init_calib_complete) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req) state_nxt = S_WAIT;
        S_WAIT:  if (!req && !fifo_empty) state_nxt = S_WRITE;
        S_WRITE: if (complete) state_nxt = S_WAIT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state != S_IDLE);
    app_en       = (state == S_WRITE) & ~cmd_done;
    app_wdf_wren = (state == S_WRITE) & ~data_done;
    app_wdf_end  = app_wdf_wren;
    frame_done   = retire & wrap;
    app_cmd      = 3'b000;
    app_wdf_mask = '0;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_begin    <= '0;
      win_end      <= '0;
      cur_addr     <= '0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      cmd_done     <= 1'b0;
      data_done    <= 1'b0;
      discard      <= 1'b0;
    end else if (!init_calib_complete) begin
      win_begin    <= '0;
      win_end      <= '0;
      cur_addr     <= '0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      cmd_done     <= 1'b0;
      data_done    <= 1'b0;
      discard      <= 1'b0;
    end else begin
      if (load || complete)  cmd_done <= 1'b0;
      else if (cmd_acc)      cmd_done <= 1'b1;
      if (load || complete)  data_done <= 1'b0;
      else if (data_acc)     data_done <= 1'b1;

      if (complete)                     discard <= 1'b0;
      else if (req && state == S_WRITE) discard <= 1'b1;

      if (req) begin
        win_begin <= wr_address_beign;
        win_end   <= wr_address_end;
        cur_addr  <= wr_address_beign;
      end else if (retire) begin
        cur_addr  <= wrap ? win_begin : next_addr;
      end

      if (load) begin
        app_addr     <= cur_addr;
        app_wdf_data <= mem[rd_ptr[PW-1:0]];
      end
    end
  end

  always_comb begin
    pack_next = pack_buf;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (32'(beat_cnt) == k) pack_next[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_din;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      pack_buf  <= '0;
      push_data <= '0;
      push_vld  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (!init_calib_complete || wr_req) begin
      beat_cnt  <= '0;
      push_vld  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      push_vld <= pix_take && (beat_cnt == LAST_BEAT);
      if (pix_take) begin
        pack_buf <= pack_next;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == LAST_BEAT) push_data <= pack_next;
      end
      if (mem_we) wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (mem_we) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (init_calib_complete && !wr_req && push_vld && fifo_full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ddr3_wr_ctrl.sv
// Bench for ddr3_wr_ctrl: queue-based word model checked every cycle, plus directed
// scenarios with literal expectations for packing, wrap, backpressure, overflow, calib and reset.
module tb_ddr3_wr_ctrl;

  localparam int DIW = 16;
  localparam int DW  = 128;
  localparam int AW  = 28;

  logic           wr_clk, rst_n, init_calib_complete, wr_req;
  logic [AW-1:0]  wr_address_beign, wr_address_end;
  logic [DIW-1:0] wr_din;
  logic           wr_din_vld;
  logic [AW-1:0]  app_addr;
  logic [2:0]     app_cmd;
  logic           app_en, app_rdy;
  logic [DW-1:0]  app_wdf_data;
  logic           app_wdf_wren, app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic           app_wdf_rdy, busy, frame_done, overflow;

  ddr3_wr_ctrl #(
    .DATA_IN_WIDTH(DIW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_INC(8), .FIFO_DEPTH(16)
  ) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_address_beign(wr_address_beign), .wr_address_end(wr_address_end),
    .wr_din(wr_din), .wr_din_vld(wr_din_vld),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: words waiting or in flight, current window and address
  logic [DW-1:0] mq[$];
  logic [AW-1:0] m_begin, m_end, m_addr, m_next;
  logic [DW-1:0] m_word, m_pend_word;
  bit            m_active, m_ovf, m_cmd_seen, m_data_seen, m_pend;
  int            m_cnt;
  int            n_writes = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  bit            log_fd[$];
  bit            cmd_now, data_now, done, wrapped, exp_fd;

  task automatic model_clear();
    mq.delete();
    m_cnt = 0; m_pend = 0; m_cmd_seen = 0; m_data_seen = 0;
    m_active = 0; m_begin = '0; m_end = '0; m_addr = '0;
  endtask

  always @(negedge wr_clk) begin
    if (!rst_n) begin
      model_clear();
      m_ovf = 0;
    end else begin
      check(busy === m_active, "busy", DW'(busy), DW'(m_active));
      check(overflow === m_ovf, "overflow", DW'(overflow), DW'(m_ovf));
      check(app_cmd === 3'b000, "app_cmd", DW'(app_cmd), '0);
      check(app_wdf_mask === '0, "app_wdf_mask", DW'(app_wdf_mask), '0);
      check(app_wdf_end === app_wdf_wren, "app_wdf_end", DW'(app_wdf_end), DW'(app_wdf_wren));
      if (app_en) begin
        check(mq.size() > 0 && !m_cmd_seen, "app_en_legal", DW'(mq.size()), DW'(m_cmd_seen));
        if (mq.size() > 0) check(app_addr === m_addr, "app_addr", DW'(app_addr), DW'(m_addr));
      end
      if (app_wdf_wren) begin
        check(mq.size() > 0 && !m_data_seen, "wren_legal", DW'(mq.size()), DW'(m_data_seen));
        if (mq.size() > 0) check(app_wdf_data === mq[0], "wdf_data", app_wdf_data, mq[0]);
      end
      cmd_now  = app_en && app_rdy;
      data_now = app_wdf_wren && app_wdf_rdy;
      done     = init_calib_complete && mq.size() > 0 &&
                 (m_cmd_seen || cmd_now) && (m_data_seen || data_now);
      m_next   = m_addr + AW'(8);
      wrapped  = (m_next >= m_end);
      exp_fd   = done && !wr_req && wrapped;
      check(frame_done === exp_fd, "frame_done", DW'(frame_done), DW'(exp_fd));

      if (!init_calib_complete) begin
        model_clear();
      end else if (wr_req) begin
        model_clear();
        m_begin = wr_address_beign; m_end = wr_address_end; m_addr = wr_address_beign;
        m_active = 1;
      end else begin
        if (m_pend) begin
          if (mq.size() >= 16) m_ovf = 1;
          else mq.push_back(m_pend_word);
          m_pend = 0;
        end
        if (cmd_now) m_cmd_seen = 1;
        if (data_now) m_data_seen = 1;
        if (done) begin
          log_addr.push_back(m_addr); log_data.push_back(mq[0]); log_fd.push_back(wrapped);
          void'(mq.pop_front());
          m_cmd_seen = 0; m_data_seen = 0;
          m_addr = wrapped ? m_begin : m_next;
          n_writes++;
        end
        if (m_active && wr_din_vld) begin
          m_word[m_cnt*DIW +: DIW] = wr_din;
          m_cnt++;
          if (m_cnt == 8) begin m_pend = 1; m_pend_word = m_word; m_cnt = 0; end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge wr_clk); #1; end
  endtask

  task automatic start_session(input logic [AW-1:0] b, input logic [AW-1:0] e);
    wr_address_beign = b; wr_address_end = e; wr_req = 1'b1;
    tick(1);
    wr_req = 1'b0;
    log_addr.delete(); log_data.delete(); log_fd.delete();
  endtask

  task automatic send_pixels(input logic [DIW-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      wr_din = start + DIW'(i); wr_din_vld = 1'b1;
      tick(1);
    end
    wr_din_vld = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (n_writes < target && c < budget) begin tick(1); c++; end
    check(n_writes >= target, name, DW'(n_writes), DW'(target));
  endtask

  task automatic wait_app_en(input string name);
    int c;
    c = 0;
    while (!app_en && c < 50) begin tick(1); c++; end
    check(app_en === 1'b1, name, DW'(app_en), 1);
  endtask

  task automatic check_all_zero(input string name);
    check({app_en, app_wdf_wren, app_wdf_end, busy, frame_done, overflow} === '0,
          {name, "_ctl"}, DW'({app_en, app_wdf_wren, app_wdf_end, busy, frame_done, overflow}), '0);
    check(app_addr === '0, {name, "_addr"}, DW'(app_addr), '0);
    check(app_wdf_data === '0, {name, "_data"}, app_wdf_data, '0);
  endtask

  int base, fd_cnt, en_cnt;
  logic [DW-1:0] exp_w;

  initial begin
    rst_n = 1'b0; init_calib_complete = 1'b0; wr_req = 1'b0;
    wr_address_beign = '0; wr_address_end = '0; wr_din = '0; wr_din_vld = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    tick(3);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick(2);
    init_calib_complete = 1'b1;
    tick(2);

    // Packing: two words, second closes the frame
    base = n_writes;
    start_session(AW'(28'h100_0000), AW'(28'h100_0010));
    send_pixels(16'h0001, 16);
    wait_writes(base + 2, 60, "pack_writes");
    tick(3);
    check(log_addr.size() == 2, "pack_count", DW'(log_addr.size()), 2);
    check(log_addr[0] === 28'h100_0000, "pack_addr0", DW'(log_addr[0]), DW'(28'h100_0000));
    exp_w = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    check(log_data[0] === exp_w, "pack_data0", log_data[0], exp_w);
    check(log_addr[1] === 28'h100_0008, "pack_addr1", DW'(log_addr[1]), DW'(28'h100_0008));
    exp_w = 128'h0010_000f_000e_000d_000c_000b_000a_0009;
    check(log_data[1] === exp_w, "pack_data1", log_data[1], exp_w);
    check(log_fd[0] == 0 && log_fd[1] == 1, "pack_frame_done", DW'({log_fd[0], log_fd[1]}), 1);

    // Wrap: three-word window, fourth word lands on begin again
    base = n_writes;
    start_session(AW'(28'h080_0000), AW'(28'h080_0018));
    send_pixels(16'h0100, 32);
    wait_writes(base + 4, 60, "wrap_writes");
    tick(3);
    check(log_addr.size() == 4, "wrap_count", DW'(log_addr.size()), 4);
    check(log_addr[0] === 28'h080_0000 && log_addr[1] === 28'h080_0008 &&
          log_addr[2] === 28'h080_0010 && log_addr[3] === 28'h080_0000, "wrap_addrs",
          DW'({log_addr[0], log_addr[1], log_addr[2], log_addr[3]}), '0);
    fd_cnt = 0;
    foreach (log_fd[i]) fd_cnt += int'(log_fd[i]);
    check(log_fd[2] == 1 && fd_cnt == 1, "wrap_frame_done", DW'(fd_cnt), 1);
    exp_w = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    check(log_data[0] === exp_w, "wrap_data0", log_data[0], exp_w);

    // Backpressure: cmd stalled 5 cycles, data stalled 2
    base = n_writes;
    start_session(AW'(28'h300_0000), AW'(28'h300_0100));
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    send_pixels(16'h00a0, 8);
    wait_app_en("bp_app_en_rise");
    exp_w = 128'h00a7_00a6_00a5_00a4_00a3_00a2_00a1_00a0;
    for (int c = 1; c <= 7; c++) begin
      check(app_en === (c <= 6), $sformatf("bp_app_en_c%0d", c), DW'(app_en), DW'(c <= 6));
      check(app_wdf_wren === (c <= 3), $sformatf("bp_wren_c%0d", c), DW'(app_wdf_wren), DW'(c <= 3));
      if (c <= 6) check(app_addr === 28'h300_0000, "bp_addr_stable", DW'(app_addr), DW'(28'h300_0000));
      if (c <= 3) check(app_wdf_data === exp_w, "bp_data_stable", app_wdf_data, exp_w);
      app_rdy = (c >= 6); app_wdf_rdy = (c >= 3);
      tick(1);
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    check(n_writes == base + 1, "bp_one_pop", DW'(n_writes), DW'(base + 1));

    // Overflow: 17 words against a stalled command port
    base = n_writes;
    start_session(AW'(28'h200_0000), AW'(28'h200_0100));
    app_rdy = 1'b0;
    send_pixels(16'h1000, 17 * 8);
    tick(3);
    check(overflow === 1'b1, "ovf_flag", DW'(overflow), 1);
    check(n_writes == base, "ovf_no_writes", DW'(n_writes), DW'(base));
    app_rdy = 1'b1;
    wait_writes(base + 16, 40, "ovf_drain_rate");
    tick(10);
    check(n_writes == base + 16, "ovf_exact_16", DW'(n_writes), DW'(base + 16));

    // Calibration loss mid-stream
    base = n_writes;
    start_session(AW'(28'h400_0000), AW'(28'h400_0100));
    send_pixels(16'h2000, 20);
    init_calib_complete = 1'b0;
    send_pixels(16'h3000, 20);
    check(busy === 1'b0 && app_en === 1'b0, "calib_idle", DW'({busy, app_en}), 0);
    init_calib_complete = 1'b1;
    send_pixels(16'h4000, 16);
    tick(20);
    check(busy === 1'b0, "calib_stays_idle", DW'(busy), 0);
    check(overflow === 1'b1, "calib_ovf_kept", DW'(overflow), 1);
    base = n_writes;

    // Reset during WRITE
    start_session(AW'(28'h500_0000), AW'(28'h500_0100));
    app_rdy = 1'b0;
    send_pixels(16'h5000, 8);
    wait_app_en("rst_app_en_rise");
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick(1);
    check_all_zero("rst_edge");
    rst_n = 1'b1;
    app_rdy = 1'b1;
    en_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      en_cnt += int'(app_en);
      tick(1);
    end
    check(en_cnt == 0, "rst_no_app_en", DW'(en_cnt), 0);
    check(n_writes == base, "rst_no_writes", DW'(n_writes), DW'(base));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
